// File: rtl/bsg_rr_relay_mux.sv
// bsg_rr_relay_mux: two-entry relay buffer shared by els_p producers.
// Round-robin arbitration at enqueue; each word carries its source tag.
module bsg_rr_relay_mux #(
    parameter int width_p = 32,
    parameter int els_p = 4,
    localparam int tag_width_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [tag_width_lp-1:0]    tag_o,
    input  logic                       ready_i
);
    logic [width_p-1:0]      r_data [2];
    logic [tag_width_lp-1:0] r_tag [2];
    logic                    r_head, r_tail, r_empty, r_full;
    logic [tag_width_lp-1:0] r_last;
    logic [els_p-1:0]        w_gnt;
    logic [tag_width_lp-1:0] w_gnt_idx, w_scan;
    logic                    w_enq, w_deq;
    // Scan backwards so the channel nearest after r_last is the final winner.
    always_comb begin
        w_gnt = '0;
        w_gnt_idx = '0;
        w_scan = '0;
        for (int k = els_p; k >= 1; k--) begin
            w_scan = tag_width_lp'((int'(r_last) + k) % els_p);
            if (v_i[w_scan]) begin
                w_gnt = '0;
                w_gnt[w_scan] = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end
    assign ready_o = w_gnt & {els_p{~r_full}};
    assign w_enq = |(v_i & ready_o);
    assign v_o = ~r_empty;
    assign w_deq = v_o & ready_i;
    assign data_o = r_data[r_head];
    assign tag_o = r_tag[r_head];
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_empty <= 1'b1;
            r_full <= 1'b0;
            r_last <= tag_width_lp'(els_p - 1);
        end else begin
            r_head <= w_deq ? ~r_head : r_head;
            r_tail <= w_enq ? ~r_tail : r_tail;
            r_full <= (r_full & ~w_deq) | (~r_empty & w_enq & ~w_deq);
            r_empty <= (r_empty & ~w_enq) | (~r_full & w_deq & ~w_enq);
            r_last <= w_enq ? w_gnt_idx : r_last;
        end
    end
    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_data[r_tail] <= data_i[w_gnt_idx*width_p +: width_p];
            r_tag[r_tail] <= w_gnt_idx;
        end
    end
endmodule
